zero_pad_stream: RTL and testbench

//  Streaming zero-padder for AlexNet conv layers; inverse of the edge-truncation stage.

---
 rtl/alexnet_pkg.sv | 15 +
 rtl/pad_pos_counter.sv | 41 ++++
 rtl/zero_pad_stream.sv | 86 ++++++++
 tb/tb_zero_pad_stream.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alexnet_pkg.sv
// Shared AlexNet streaming definitions.
// Counter/data width defaults and padded-dimension helper.
package alexnet_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int DATA_W_DEF = 8;

  function automatic int padded_dim(
    input int dim,
    input int pad
  );
    return dim + 2 * pad;
  endfunction

endpackage

// File: rtl/pad_pos_counter.sv
// Raster col/row position counter.
// Advances on en, wraps at PW x PH.
module pad_pos_counter
  import alexnet_pkg::*;
#(
  parameter int PW    = 5,
  parameter int PH    = 5,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last_pos
);

  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(PW - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(PH - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic col_wrap;
  logic row_wrap;

  assign col_wrap = (col == COL_MAX);
  assign row_wrap = (row == ROW_MAX);
  assign last_pos = col_wrap && row_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      col <= col_wrap ? '0 : col + ONE;
      if (col_wrap) begin
        row <= row_wrap ? '0 : row + ONE;
      end
    end
  end

endmodule

// File: rtl/zero_pad_stream.sv
// Streaming zero-padder: WIDTH x HEIGHT raster in,
// (WIDTH+2*PAD) x (HEIGHT+2*PAD) raster out.
module zero_pad_stream
  import alexnet_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int HEIGHT = 3,
  parameter int PAD    = 1,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done
);

  localparam int PW = padded_dim(WIDTH, PAD);
  localparam int PH = padded_dim(HEIGHT, PAD);

  localparam logic [CNT_W-1:0] LO     = CNT_W'(PAD);
  localparam logic [CNT_W-1:0] COL_HI = CNT_W'(PAD + WIDTH);
  localparam logic [CNT_W-1:0] ROW_HI = CNT_W'(PAD + HEIGHT);

  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic             last_pos;
  logic             interior;
  logic             load;
  logic             step;

  pad_pos_counter #(
    .PW    (PW),
    .PH    (PH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (step),
    .col      (col),
    .row      (row),
    .last_pos (last_pos)
  );

  // Without padding every position is interior.
  generate
    if (PAD == 0) begin : g_nopad
      logic unused_pos;
      assign unused_pos = ^{col, row};
      assign interior   = 1'b1;
    end else begin : g_pad
      assign interior = (col >= LO) && (col < COL_HI)
                     && (row >= LO) && (row < ROW_HI);
    end
  endgenerate

  assign load     = !out_valid || out_ready;
  assign in_ready = interior && load;
  assign step     = load && (!interior || in_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= out_valid && out_ready && out_last;
      if (step) begin
        out_valid <= 1'b1;
        out_data  <= interior ? in_data : '0;
        out_last  <= last_pos;
      end else if (load) begin
        // Interior cell with no input yet: bubble.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zero_pad_stream.sv
// Directed bench for zero_pad_stream.
// Main DUT uses PAD=1; second instance uses PAD=0.
module tb_zero_pad_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_last, done;
  logic [7:0] out_data;
  logic       p0_in_ready, p0_out_valid, p0_out_last, p0_done;
  logic [7:0] p0_out_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got_d[$];
  logic       got_l[$];
  int done_n, done_cyc, first_cyc, last_cyc, stall_bad, stab_bad;

  always #5 clk = ~clk;

  zero_pad_stream #(
    .WIDTH(3), .HEIGHT(3), .PAD(1), .DATA_W(8), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done)
  );

  zero_pad_stream #(
    .WIDTH(3), .HEIGHT(3), .PAD(0), .DATA_W(8), .CNT_W(8)
  ) dut_p0 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (p0_in_ready),
    .out_valid (p0_out_valid),
    .out_data  (p0_out_data),
    .out_ready (out_ready),
    .out_last  (p0_out_last),
    .done      (p0_done)
  );

  function automatic logic [7:0] exp_pad(input int k, input int base);
    int f, p, r, c;
    f = k / 25;
    p = k % 25;
    r = p / 5;
    c = p % 5;
    if (r >= 1 && r <= 3 && c >= 1 && c <= 3)
      return 8'(base + 9 * f + (r - 1) * 3 + (c - 1));
    return 8'd0;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic run(input bit sel, input int n_in, input int base,
                     input bit toggle, input int gap_at,
                     input int gap_len, input int n_out);
    int sent = 0;
    int gap = 0;
    int cyc = 0;
    bit held = 1'b0;
    bit gapping;
    logic [7:0] hd;
    logic hl, rdy, ov, ol, dn;
    logic [7:0] od;
    got_d.delete();
    got_l.delete();
    done_n = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1;
    stall_bad = 0; stab_bad = 0;
    hd = 8'd0; hl = 1'b0;
    while (got_d.size() < n_out && cyc < 400) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      gapping = (sent == gap_at) && (gap < gap_len);
      in_valid = !gapping && (sent < n_in);
      in_data = 8'(base + sent);
      @(negedge clk);
      rdy = sel ? p0_in_ready : in_ready;
      ov = sel ? p0_out_valid : out_valid;
      od = sel ? p0_out_data : out_data;
      ol = sel ? p0_out_last : out_last;
      dn = sel ? p0_done : done;
      if (held && (!ov || od !== hd || ol !== hl)) stab_bad++;
      held = ov && !out_ready;
      hd = od;
      hl = ol;
      if (held && rdy) stall_bad++;
      if (gapping) gap++;
      if (in_valid && rdy) sent++;
      if (ov && out_ready) begin
        got_d.push_back(od);
        got_l.push_back(ol);
        if (first_cyc < 0) first_cyc = cyc;
        if (ol) last_cyc = cyc;
      end
      if (dn) begin
        done_n++;
        done_cyc = cyc;
      end
      @(posedge clk);
      #1 cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    dn = sel ? p0_done : done;
    if (dn) begin
      done_n++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_cmp += 6;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    if (out_data !== 8'd0) begin n_bad++; $display("FAIL rst_data: got %0d want 0", out_data); end
    if (out_last !== 1'b0) begin n_bad++; $display("FAIL rst_last: got %b want 0", out_last); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (p0_in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_p0_in_ready: got %b want 1", p0_in_ready); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    run(1'b0, 9, 1, 1'b0, -1, 0, 25);
    n_cmp += 5;
    if (got_d.size() !== 25) begin n_bad++; $display("FAIL basic_count: got %0d want 25", got_d.size()); end
    if (first_cyc !== 1) begin n_bad++; $display("FAIL basic_first: got %0d want 1", first_cyc); end
    if (last_cyc - first_cyc !== 24) begin n_bad++; $display("FAIL basic_span: got %0d want 24", last_cyc - first_cyc); end
    if (done_n !== 1) begin n_bad++; $display("FAIL basic_done_n: got %0d want 1", done_n); end
    if (done_cyc !== last_cyc + 1) begin n_bad++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, last_cyc + 1); end
    for (int i = 0; i < 25; i++) begin
      n_cmp += 2;
      if (got_d[i] !== exp_pad(i, 1)) begin n_bad++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, got_d[i], exp_pad(i, 1)); end
      if (got_l[i] !== (i == 24)) begin n_bad++; $display("FAIL basic_last[%0d]: got %b want %b", i, got_l[i], i == 24); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    run(1'b0, 9, 1, 1'b1, -1, 0, 25);
    n_cmp += 5;
    if (got_d.size() !== 25) begin n_bad++; $display("FAIL bp_count: got %0d want 25", got_d.size()); end
    if (stall_bad !== 0) begin n_bad++; $display("FAIL bp_in_ready_stall: got %0d want 0", stall_bad); end
    if (stab_bad !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d want 0", stab_bad); end
    if (done_n !== 1) begin n_bad++; $display("FAIL bp_done_n: got %0d want 1", done_n); end
    if (done_cyc !== last_cyc + 1) begin n_bad++; $display("FAIL bp_done_cyc: got %0d want %0d", done_cyc, last_cyc + 1); end
    for (int i = 0; i < 25; i++) begin
      n_cmp += 2;
      if (got_d[i] !== exp_pad(i, 1)) begin n_bad++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, got_d[i], exp_pad(i, 1)); end
      if (got_l[i] !== (i == 24)) begin n_bad++; $display("FAIL bp_last[%0d]: got %b want %b", i, got_l[i], i == 24); end
    end
  endtask

  task automatic test_gap();
    do_reset();
    run(1'b0, 9, 1, 1'b0, 4, 3, 25);
    n_cmp += 3;
    if (got_d.size() !== 25) begin n_bad++; $display("FAIL gap_count: got %0d want 25", got_d.size()); end
    if (last_cyc - first_cyc !== 27) begin n_bad++; $display("FAIL gap_span: got %0d want 27", last_cyc - first_cyc); end
    if (done_n !== 1) begin n_bad++; $display("FAIL gap_done_n: got %0d want 1", done_n); end
    for (int i = 0; i < 25; i++) begin
      n_cmp++;
      if (got_d[i] !== exp_pad(i, 1)) begin n_bad++; $display("FAIL gap_data[%0d]: got %0d want %0d", i, got_d[i], exp_pad(i, 1)); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    run(1'b0, 9, 1, 1'b0, -1, 0, 12);
    n_cmp += 2;
    if (got_d.size() !== 12) begin n_bad++; $display("FAIL mr_pre_count: got %0d want 12", got_d.size()); end
    if (out_data !== 8'd5) begin n_bad++; $display("FAIL mr_pre_data: got %0d want 5", out_data); end
    reset = 1'b0;
    #1;
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mr_valid: got %b want 0", out_valid); end
    if (out_data !== 8'd0) begin n_bad++; $display("FAIL mr_data: got %0d want 0", out_data); end
    if (out_last !== 1'b0) begin n_bad++; $display("FAIL mr_last: got %b want 0", out_last); end
    if (dut.u_cnt.col !== 8'd0) begin n_bad++; $display("FAIL mr_col: got %0d want 0", dut.u_cnt.col); end
    if (dut.u_cnt.row !== 8'd0) begin n_bad++; $display("FAIL mr_row: got %0d want 0", dut.u_cnt.row); end
    do_reset();
    run(1'b0, 9, 1, 1'b0, -1, 0, 25);
    n_cmp += 2;
    if (got_d.size() !== 25) begin n_bad++; $display("FAIL mr_count: got %0d want 25", got_d.size()); end
    if (done_n !== 1) begin n_bad++; $display("FAIL mr_done_n: got %0d want 1", done_n); end
    for (int i = 0; i < 25; i++) begin
      n_cmp++;
      if (got_d[i] !== exp_pad(i, 1)) begin n_bad++; $display("FAIL mr_data[%0d]: got %0d want %0d", i, got_d[i], exp_pad(i, 1)); end
    end
  endtask

  task automatic test_pad0();
    do_reset();
    run(1'b1, 9, 1, 1'b0, -1, 0, 9);
    n_cmp += 5;
    if (got_d.size() !== 9) begin n_bad++; $display("FAIL p0_count: got %0d want 9", got_d.size()); end
    if (first_cyc !== 1) begin n_bad++; $display("FAIL p0_latency: got %0d want 1", first_cyc); end
    if (last_cyc - first_cyc !== 8) begin n_bad++; $display("FAIL p0_span: got %0d want 8", last_cyc - first_cyc); end
    if (done_n !== 1) begin n_bad++; $display("FAIL p0_done_n: got %0d want 1", done_n); end
    if (done_cyc !== last_cyc + 1) begin n_bad++; $display("FAIL p0_done_cyc: got %0d want %0d", done_cyc, last_cyc + 1); end
    for (int i = 0; i < 9; i++) begin
      n_cmp += 2;
      if (got_d[i] !== 8'(i + 1)) begin n_bad++; $display("FAIL p0_data[%0d]: got %0d want %0d", i, got_d[i], i + 1); end
      if (got_l[i] !== (i == 8)) begin n_bad++; $display("FAIL p0_last[%0d]: got %b want %b", i, got_l[i], i == 8); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run(1'b0, 18, 1, 1'b0, -1, 0, 50);
    n_cmp += 4;
    if (got_d.size() !== 50) begin n_bad++; $display("FAIL b2b_count: got %0d want 50", got_d.size()); end
    if (last_cyc - first_cyc !== 49) begin n_bad++; $display("FAIL b2b_span: got %0d want 49", last_cyc - first_cyc); end
    if (done_n !== 2) begin n_bad++; $display("FAIL b2b_done_n: got %0d want 2", done_n); end
    if (done_cyc !== last_cyc + 1) begin n_bad++; $display("FAIL b2b_done_cyc: got %0d want %0d", done_cyc, last_cyc + 1); end
    for (int i = 0; i < 50; i++) begin
      n_cmp += 2;
      if (got_d[i] !== exp_pad(i, 1)) begin n_bad++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, got_d[i], exp_pad(i, 1)); end
      if (got_l[i] !== (i % 25 == 24)) begin n_bad++; $display("FAIL b2b_last[%0d]: got %b want %b", i, got_l[i], i % 25 == 24); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gap();
    test_mid_reset();
    test_pad0();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
